// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: up to N_WP pending slot results per cycle are registered onto RF write ports.
// Optional same-cycle destination conflict deferral is enabled with `define WB_CONFLICT_CHECK_EN.
module wb_port_arbiter #(
  parameter int N_REQ       = 10,
  parameter int N_WP        = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_WP-1:0]          wr_en,
  output logic [N_WP*ADDR_W-1:0]   wr_addr,
  output logic [N_WP*DATA_W-1:0]   wr_data,
  output logic                     stall,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(N_WP + 1);

  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [N_REQ-1:0] grant;
  logic [N_WP-1:0]  port_vld;
  logic [IDX_W-1:0] port_sel [N_WP];
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] n_gnt;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_idx;
  logic             clash;

  // Walk slots from ptr in circular order; the k-th winner is bound to port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    for (int k = 0; k < N_WP; k++) port_sel[k] = '0;
    last_idx = '0;
    n_gnt    = '0;
    scan_sum = '0;
    scan_idx = '0;
    clash    = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      scan_sum = {1'b0, ptr_reg} + (IDX_W+1)'(j);
      if (scan_sum >= (IDX_W+1)'(N_REQ)) scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
      scan_idx = scan_sum[IDX_W-1:0];
      clash    = 1'b0;
`ifdef WB_CONFLICT_CHECK_EN
      for (int k = 0; k < N_WP; k++) begin
        if (port_vld[k] && (addr_arr[port_sel[k]] == addr_arr[scan_idx])) clash = 1'b1;
      end
`endif
      if (req_valid[scan_idx] && (n_gnt < CNT_W'(N_WP)) && !clash) begin
        grant[scan_idx] = 1'b1;
        for (int k = 0; k < N_WP; k++) begin
          if (n_gnt == CNT_W'(k)) begin
            port_vld[k] = 1'b1;
            port_sel[k] = scan_idx;
          end
        end
        last_idx = scan_idx;
        n_gnt    = n_gnt + 1'b1;
      end
    end
  end

  // Grants and stall are forced low while reset is held.
  assign req_ready = reset ? '0 : grant;
  assign stall     = !reset && (|(req_valid & ~grant));
  assign stall_cnt = stall_cnt_reg;

  always_comb begin
    ptr_next = ptr_reg;
    if (|port_vld) begin
      ptr_next = (last_idx == IDX_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != '1)) stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  generate
    for (gi = 0; gi < N_WP; gi++) begin : g_port
      logic              en_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] data_reg;

      // Idle ports drop wr_en but keep their last address/data.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          en_reg   <= 1'b0;
          addr_reg <= '0;
          data_reg <= '0;
        end else begin
          en_reg <= port_vld[gi];
          if (port_vld[gi]) begin
            addr_reg <= addr_arr[port_sel[gi]];
            data_reg <= data_arr[port_sel[gi]];
          end
        end
      end

      assign wr_en[gi]                       = en_reg;
      assign wr_addr[gi*ADDR_W +: ADDR_W]    = addr_reg;
      assign wr_data[gi*DATA_W +: DATA_W]    = data_reg;
    end
  endgenerate

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback arbiter between the VLIW functional-unit slots and the register file write ports. Each cycle, up to `N_WP` pending slot results are selected round-robin. The winners are registered onto the register file write ports one cycle later. Losers are back-pressured through `req_ready`. The block sits between the slot execute stages of `processor` and `rf`, and lets ten slots share a small number of physical write ports.

## Interface
- `N_REQ`, 10: number of requesting slots, one per bundle slot.
- `N_WP`, 2: number of register file write ports; 1 ≤ `N_WP` ≤ `N_REQ`.
- `DATA_W`, 32: writeback data width.
- `ADDR_W`, 5: register index width.
- `STALL_CNT_W`, 16: width of the saturating stall counter.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input `N_REQ`: slot i has a result pending.
- `req_addr` input `N_REQ*ADDR_W`: destination register; slot i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data` input `N_REQ*DATA_W`: result data, packed the same way as `req_addr`.
- `req_ready` output `N_REQ`: grant; combinational, same cycle.
- `wr_en` output `N_WP`: write port k enable, registered.
- `wr_addr` output `N_WP*ADDR_W`: write port k address, registered.
- `wr_data` output `N_WP*DATA_W`: write port k data, registered.
- `stall` output 1: some valid request is not granted this cycle; combinational.
- `stall_cnt` output `STALL_CNT_W`: count of cycles with `stall`=1; saturates, registered.

## Operation
- **Internal state:** round-robin pointer `ptr` in 0..N_REQ-1.
- **Scan order:** ptr, ptr+1, …, ptr+N_REQ-1, all mod `N_REQ`.
- **Granting:** the first `N_WP` valid slots in scan order are granted. The k-th granted slot drives write port k.
- **Grant condition:** `req_ready[i]` = 1 only if `req_valid[i]` = 1 and slot i is granted.
- **Transfer:** a transfer occurs when valid and ready are both 1 at a rising edge.
- **Requester rule:** the requester holds `req_valid`, `req_addr` and `req_data` stable until it is granted.
- **Port loading:** on each edge, port k loads `wr_en`=1 plus the addr/data of its grant. Ports with no grant load `wr_en`=0; their addr/data hold their previous values.
- **Pointer update:** `ptr` ← (index of last granted slot + 1) mod `N_REQ`. With no grant, `ptr` is unchanged.
- **Stall:** `stall` = OR over i of (`req_valid[i]` AND NOT `req_ready[i]`).
- **Stall counter:** `stall_cnt` increments on each edge where `stall`=1, and saturates at all-ones without wrapping.
- **Address uniqueness:** with `WB_CONFLICT_CHECK_EN` undefined, same-address grants in one cycle are allowed; ports are written in ascending k and the highest k wins in `rf`.
- **Reset, asynchronous:**
  - `ptr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `stall_cnt`=0.
  - While `reset`=1: `req_ready`=0 and `stall`=0.
  - A reset mid-transfer drops the in-flight port writes. Requesters keep their valid and are re-arbitrated from `ptr`=0.

## Timing
- **Grant latency:** 0 cycles from `req_valid` to `req_ready`.
- **Write latency:** 1 cycle from grant edge to `wr_en`/`wr_addr`/`wr_data`, which are valid for exactly one cycle per grant.
- **Throughput:** `N_WP` writes per cycle.
- **Worst-case wait:** a continuously valid slot is granted within ceil(`N_REQ`/`N_WP`) cycles when the conflict check is off.
- **Combinational paths:** `req_valid` → `req_ready` and `req_valid` → `stall`. There is no combinational path to `wr_*`.

## Configuration
- Macro: `WB_CONFLICT_CHECK_EN`.
- **Defined:**
  - During the scan, a valid slot whose `req_addr` equals that of a slot already granted this cycle is skipped (deferred, `req_ready`=0).
  - The scan continues for the remaining ports.
  - The deferred slot counts toward `stall`.
  - No two ports carry the same `wr_addr` in a cycle.
- **Undefined:** no comparison is made, as described under Operation.

## Test plan
1. **Reset values:** assert `reset` for 3 cycles → all `wr_en`=0, `wr_addr`/`wr_data`=0, `stall_cnt`=0, `req_ready`=0 even with all `req_valid`=1.
2. **Single request:** slot 5 only, addr 2, data 0x41200000 → `req_ready[5]`=1 the same cycle; next cycle `wr_en`=2'b01, port0 addr 2, data 0x41200000; `stall`=0.
3. **Full rotation:** all 10 slots valid, held until granted → grant pairs (0,1),(2,3),(4,5),(6,7),(8,9) on successive cycles; `stall`=1 for the first 4 cycles and 0 on the fifth; `stall_cnt`=4 afterward.
4. **Same-address conflict:** `ptr`=0, slots 3 and 7 valid, both addr 8.
   - Macro defined → cycle 1 grants slot 3 only, `stall`=1; cycle 2 grants slot 7.
   - Macro undefined → both granted in one cycle, port0 from slot 3 and port1 from slot 7.
5. **Reset mid-operation:** assert `reset` asynchronously while `wr_en`=2'b11 → outputs clear before the next edge; after release, arbitration restarts at slot 0.
6. **Counter saturation:** `STALL_CNT_W`=4, 3 slots continuously valid with `N_WP`=2 for 40 cycles → `stall_cnt` reaches 15 and stays at 15.
